// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback stage: queue entry layout,
// arbitration grant encoding and default queue depth / starvation bound.
package wb_pkg;

  localparam int DEFAULT_FIFO_DEPTH = 2;
  localparam int DEFAULT_STARVE_MAX = 2;
  localparam int RD_W               = 5;
  localparam int DATA_W             = 64;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_MEM,
    GRANT_ALU
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// Single-source result queue: power-of-two depth, pointers carry one extra
// wrap bit so full and empty are distinguishable.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t pushData_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t head_o
);

  localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  wb_entry_t  mem_q [DEPTH];
  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic        doPush, doPop;

  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                   (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);

  // A full queue refuses the push even if it is popped this cycle.
  assign doPush = push_i && !full_o;
  assign doPop  = pop_i && !empty_o;
  assign head_o = mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback arbiter merging ALU and load results into one register-file write
// port. Optional busy scoreboard is built when WB_SCOREBOARD_EN is defined.
module wb_stage
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [RD_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [RD_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_out
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic              iss_valid,
  input  logic [RD_W-1:0]   iss_rd,
  output logic [31:0]       busy
`endif
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  wb_entry_t         aluHead, memHead;
  logic              aluFull, aluEmpty, memFull, memEmpty;
  logic              aluPop, memPop;
  grant_e            grant;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic [RD_W-1:0]   wbRd_q, wbRd_d;
  logic [DATA_W-1:0] wbOut_q, wbOut_d;

  assign alu_ready = !aluFull;
  assign mem_ready = !memFull;
  assign aluPop    = (grant == GRANT_ALU);
  assign memPop    = (grant == GRANT_MEM);

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_aluFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (alu_valid),
    .pushData_i (wb_entry_t'({alu_rd, alu_data})),
    .pop_i      (aluPop),
    .full_o     (aluFull),
    .empty_o    (aluEmpty),
    .head_o     (aluHead)
  );

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_memFifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (mem_valid),
    .pushData_i (wb_entry_t'({mem_rd, mem_data})),
    .pop_i      (memPop),
    .full_o     (memFull),
    .empty_o    (memEmpty),
    .head_o     (memHead)
  );

  // Loads normally win, but a waiting ALU entry is forced through once the
  // starvation bound is reached.
  always_comb begin
    grant = GRANT_NONE;
    if (!aluEmpty && (starveCnt_q == CNT_W'(STARVE_MAX))) grant = GRANT_ALU;
    else if (!memEmpty)                                   grant = GRANT_MEM;
    else if (!aluEmpty)                                   grant = GRANT_ALU;
  end

  always_comb begin
    starveCnt_d = starveCnt_q;
    wbRd_d      = '0;
    wbOut_d     = '0;
    if (grant == GRANT_MEM) begin
      wbRd_d  = memHead.rd;
      wbOut_d = memHead.data;
    end else if (grant == GRANT_ALU) begin
      wbRd_d  = aluHead.rd;
      wbOut_d = aluHead.data;
    end
    if (aluEmpty || grant == GRANT_ALU) starveCnt_d = '0;
    else if (grant == GRANT_MEM)        starveCnt_d = starveCnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starveCnt_q <= '0;
      wbRd_q      <= '0;
      wbOut_q     <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      wbRd_q      <= wbRd_d;
      wbOut_q     <= wbOut_d;
    end
  end

  assign wb_rd  = wbRd_q;
  assign wb_out = wbOut_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // A new issue to a register outranks the retirement clearing it.
  always_comb begin
    busy_d = busy_q;
    if (wbRd_d != '0) busy_d[wbRd_d] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy = busy_q;
`endif

endmodule
